// File: rtl/tri_near_clipper.sv
// Streaming near-plane triangle clipper: culls, passes through or splits triangles at z = 0.
// Optional statistics counters are built when CLIP_STATS_EN is defined.
module tri_near_clipper #(
  parameter int unsigned VERTEX_WIDTH = 32,
  parameter int unsigned FRAC_BITS    = 16
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      in_valid_i,
  output logic                      in_ready_o,
  input  logic [12*VERTEX_WIDTH-1:0] in_vtx_i,
  output logic                      out_valid_o,
  input  logic                      out_ready_i,
  output logic [12*VERTEX_WIDTH-1:0] out_vtx_o,
  output logic                      out_last_o,
  output logic                      busy_o,
  output logic [15:0]               cull_count_o,
  output logic [15:0]               clip_count_o
);

  localparam int unsigned VW = VERTEX_WIDTH;
  localparam int unsigned FB = FRAC_BITS;
  localparam int unsigned XW = 4 * VW;
  localparam int unsigned TW = 12 * VW;
  localparam int unsigned CW = $clog2(FB);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_CLASSIFY = 3'd1;
  localparam logic [2:0] S_DIV      = 3'd2;
  localparam logic [2:0] S_LERP     = 3'd3;
  localparam logic [2:0] S_EMIT     = 3'd4;

  // Component j of a vertex, sign-extended by one bit so differences cannot overflow.
  function automatic logic signed [VW:0] comp(input logic [XW-1:0] v, input int unsigned j);
    logic [VW-1:0] s;
    s = v[j*VW +: VW];
    comp = {s[VW-1], s};
  endfunction

  function automatic logic [5:0] outcode(input logic [XW-1:0] v);
    logic signed [VW:0] x, y, z, w;
    x = comp(v, 0);
    y = comp(v, 1);
    z = comp(v, 2);
    w = comp(v, 3);
    outcode = {x < -w, x > w, y < -w, y > w, z[VW], z > w};
  endfunction

  logic [2:0]    state_q, state_d;
  logic [TW-1:0] tri_q, tri_d;
  logic [XW-1:0] a_q, a_d, b_q, b_d, c_q, c_d;
  logic [XW-1:0] i0_q, i0_d, i1_q, i1_d;
  logic          one_in_q, one_in_d, k_q, k_d;
  logic [VW:0]   rem_q, rem_d;
  logic [FB-1:0] quo_q, quo_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [TW-1:0] out_vtx_q, out_vtx_d;
  logic          out_valid_q, out_valid_d, out_last_q, out_last_d;
  logic          in_ready_q, in_ready_d, busy_q, busy_d;

  // Classification of the held triangle
  logic [XW-1:0] v0_c, v1_c, v2_c, a_c, b_c, c_c;
  logic [2:0]    near_c, odd_c;
  logic          cull_c, one_in_c;

  assign v0_c     = tri_q[0    +: XW];
  assign v1_c     = tri_q[XW   +: XW];
  assign v2_c     = tri_q[2*XW +: XW];
  assign cull_c   = |(outcode(v0_c) & outcode(v1_c) & outcode(v2_c));
  assign near_c   = {v2_c[3*VW-1], v1_c[3*VW-1], v0_c[3*VW-1]};
  assign one_in_c = (near_c == 3'b110) || (near_c == 3'b101) || (near_c == 3'b011);
  assign odd_c    = one_in_c ? ~near_c : near_c;

  always_comb begin
    if (odd_c[0]) begin
      a_c = v0_c; b_c = v1_c; c_c = v2_c;
    end else if (odd_c[1]) begin
      a_c = v1_c; b_c = v2_c; c_c = v0_c;
    end else begin
      a_c = v2_c; b_c = v0_c; c_c = v1_c;
    end
  end

  // Inside endpoint p and outside endpoint q of the intersection being computed
  logic [XW-1:0]      p_c, q_c;
  logic signed [VW:0] den_c;
  logic [VW:0]        rem_cur_c;
  logic [VW+1:0]      shl_c;
  logic               ge_c;
  logic [XW-1:0]      lerp_c;

  always_comb begin
    if (one_in_q) begin
      p_c = a_q;
      q_c = k_q ? c_q : b_q;
    end else begin
      p_c = k_q ? c_q : b_q;
      q_c = a_q;
    end
  end

  assign den_c     = comp(p_c, 2) - comp(q_c, 2);
  assign rem_cur_c = (cnt_q == '0) ? comp(p_c, 2) : rem_q;
  assign shl_c     = {rem_cur_c, 1'b0};
  assign ge_c      = shl_c >= {1'b0, den_c};

  always_comb begin
    logic signed [VW:0]       diff;
    logic signed [FB+VW+1:0]  prod;
    lerp_c = '0;
    for (int unsigned j = 0; j < 4; j++) begin
      diff = comp(q_c, j) - comp(p_c, j);
      prod = $signed({1'b0, quo_q}) * diff;
      lerp_c[j*VW +: VW] = p_c[j*VW +: VW] + VW'(prod >>> FB);
    end
    lerp_c[2*VW +: VW] = '0;
  end

  always_comb begin
    state_d     = state_q;
    tri_d       = tri_q;
    a_d         = a_q;
    b_d         = b_q;
    c_d         = c_q;
    i0_d        = i0_q;
    i1_d        = i1_q;
    one_in_d    = one_in_q;
    k_d         = k_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    cnt_d       = cnt_q;
    out_vtx_d   = out_vtx_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid_i && in_ready_q) begin
          tri_d   = in_vtx_i;
          state_d = S_CLASSIFY;
        end
      end
      S_CLASSIFY: begin
        a_d      = a_c;
        b_d      = b_c;
        c_d      = c_c;
        one_in_d = one_in_c;
        k_d      = 1'b0;
        cnt_d    = '0;
        if (cull_c) begin
          state_d = S_IDLE;
        end else if (near_c == 3'b000) begin
          state_d     = S_EMIT;
          out_vtx_d   = tri_q;
          out_valid_d = 1'b1;
          out_last_d  = 1'b1;
        end else begin
          state_d = S_DIV;
        end
      end
      S_DIV: begin
        // One restoring step per cycle; the remainder starts at z_p since t < 1.
        rem_d = ge_c ? (VW+1)'(shl_c - {1'b0, den_c}) : shl_c[VW:0];
        quo_d = {quo_q[FB-2:0], ge_c};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(FB - 1)) begin
          cnt_d   = '0;
          state_d = S_LERP;
        end
      end
      S_LERP: begin
        if (!k_q) begin
          i0_d    = lerp_c;
          k_d     = 1'b1;
          state_d = S_DIV;
        end else begin
          i1_d        = lerp_c;
          state_d     = S_EMIT;
          out_valid_d = 1'b1;
          if (one_in_q) begin
            out_vtx_d  = {lerp_c, i0_q, a_q};
            out_last_d = 1'b1;
          end else begin
            out_vtx_d  = {c_q, b_q, i0_q};
            out_last_d = 1'b0;
          end
        end
      end
      S_EMIT: begin
        if (out_ready_i) begin
          if (out_last_q) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            state_d     = S_IDLE;
          end else begin
            out_vtx_d  = {i1_q, c_q, i0_q};
            out_last_d = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    in_ready_d = (state_d == S_IDLE);
    busy_d     = (state_d != S_IDLE);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      tri_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      c_q         <= '0;
      i0_q        <= '0;
      i1_q        <= '0;
      one_in_q    <= 1'b0;
      k_q         <= 1'b0;
      rem_q       <= '0;
      quo_q       <= '0;
      cnt_q       <= '0;
      out_vtx_q   <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      in_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      tri_q       <= tri_d;
      a_q         <= a_d;
      b_q         <= b_d;
      c_q         <= c_d;
      i0_q        <= i0_d;
      i1_q        <= i1_d;
      one_in_q    <= one_in_d;
      k_q         <= k_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      cnt_q       <= cnt_d;
      out_vtx_q   <= out_vtx_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready_o  = in_ready_q;
  assign out_valid_o = out_valid_q;
  assign out_vtx_o   = out_vtx_q;
  assign out_last_o  = out_last_q;
  assign busy_o      = busy_q;

`ifdef CLIP_STATS_EN
  // Saturating event counters, sampled as CLASSIFY resolves
  logic [15:0] cull_cnt_q, cull_cnt_d, clip_cnt_q, clip_cnt_d;

  always_comb begin
    cull_cnt_d = cull_cnt_q;
    clip_cnt_d = clip_cnt_q;
    if (state_q == S_CLASSIFY && cull_c && cull_cnt_q != 16'hFFFF)
      cull_cnt_d = cull_cnt_q + 16'd1;
    if (state_q == S_CLASSIFY && !cull_c && near_c != 3'b000 && clip_cnt_q != 16'hFFFF)
      clip_cnt_d = clip_cnt_q + 16'd1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cull_cnt_q <= '0;
      clip_cnt_q <= '0;
    end else begin
      cull_cnt_q <= cull_cnt_d;
      clip_cnt_q <= clip_cnt_d;
    end
  end

  assign cull_count_o = cull_cnt_q;
  assign clip_count_o = clip_cnt_q;
`else
  assign cull_count_o = 16'd0;
  assign clip_count_o = 16'd0;
`endif

endmodule

// File: tb/tb_tri_near_clipper.sv
// Self-checking bench for tri_near_clipper: directed test-plan cases plus random triangles
// compared against a behavioural clipping model.
module tb_tri_near_clipper;

  localparam int unsigned XW = 128;
  localparam int unsigned TW = 384;
`ifdef CLIP_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic          in_valid_i = 1'b0;
  logic          in_ready_o;
  logic [TW-1:0] in_vtx_i = '0;
  logic          out_valid_o;
  logic          out_ready_i = 1'b1;
  logic [TW-1:0] out_vtx_o;
  logic          out_last_o;
  logic          busy_o;
  logic [15:0]   cull_count_o, clip_count_o;

  tri_near_clipper dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_vtx_i(in_vtx_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_vtx_o(out_vtx_o),
    .out_last_o(out_last_o), .busy_o(busy_o),
    .cull_count_o(cull_count_o), .clip_count_o(clip_count_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct { logic [TW-1:0] v; logic last; } exp_t;
  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   exp_cull = 0;
  int   exp_clip = 0;
  bit   bp_hold = 1'b0;
  bit   rand_rdy = 1'b0;

  task automatic chk(input string name, input logic [TW-1:0] act, input logic [TW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [XW-1:0] mk(input int x, input int y, input int z, input int w);
    return {w, z, y, x};
  endfunction

  function automatic longint gc(input logic [XW-1:0] v, input int j);
    return longint'($signed(v[j*32 +: 32]));
  endfunction

  // Intersection from inside vertex p toward outside vertex q at z = 0
  function automatic logic [XW-1:0] isect(input logic [XW-1:0] p, input logic [XW-1:0] q);
    longint zp, zq, t, d, s;
    logic [XW-1:0] r;
    zp = gc(p, 2);
    zq = gc(q, 2);
    t = (zp <<< 16) / (zp - zq);
    for (int j = 0; j < 4; j++) begin
      d = gc(q, j) - gc(p, j);
      s = (t * d) >>> 16;
      r[j*32 +: 32] = 32'(gc(p, j) + s);
    end
    r[64 +: 32] = '0;
    return r;
  endfunction

  function automatic void model(input logic [TW-1:0] t, output bit cull, output bit clip,
                                output int n, output logic [TW-1:0] o0, output logic [TW-1:0] o1);
    logic [XW-1:0] v[3];
    logic [XW-1:0] a, b, c, i0, i1;
    bit near[3];
    int nin, r;
    bit all_out, o;
    longint x, y, z, w;
    o0 = '0; o1 = '0; n = 0; cull = 1'b0; clip = 1'b0; nin = 0; r = 0;
    for (int k = 0; k < 3; k++) v[k] = t[k*XW +: XW];
    for (int pl = 0; pl < 6; pl++) begin
      all_out = 1'b1;
      for (int k = 0; k < 3; k++) begin
        x = gc(v[k], 0); y = gc(v[k], 1); z = gc(v[k], 2); w = gc(v[k], 3);
        case (pl)
          0: o = x < -w;
          1: o = x > w;
          2: o = y < -w;
          3: o = y > w;
          4: o = z < 0;
          default: o = z > w;
        endcase
        all_out &= o;
      end
      if (all_out) cull = 1'b1;
    end
    if (cull) return;
    for (int k = 0; k < 3; k++) begin
      near[k] = gc(v[k], 2) < 0;
      if (!near[k]) nin++;
    end
    if (nin == 3) begin
      n = 1; o0 = t;
      return;
    end
    clip = 1'b1;
    for (int k = 2; k >= 0; k--) if (near[k] == (nin == 2)) r = k;
    a = v[r]; b = v[(r + 1) % 3]; c = v[(r + 2) % 3];
    if (nin == 1) begin
      n = 1;
      o0 = {isect(a, c), isect(a, b), a};
    end else begin
      i0 = isect(b, a);
      i1 = isect(c, a);
      n = 2;
      o0 = {c, b, i0};
      o1 = {i1, c, i0};
    end
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic wait_ready(input string name);
    int n = 0;
    while (!in_ready_o && n < 3000) begin
      tick();
      n++;
    end
    if (!in_ready_o) begin
      checks++; errors++;
      $display("FAIL %s: in_ready_o still %b after %0d cycles, expected 1", name, in_ready_o, n);
    end
  endtask

  // lat > 0 checks the cycle (accept = cycle 0) of first output, or of in_ready_o for a cull
  task automatic send(input logic [TW-1:0] t, input int lat);
    bit cull, clip;
    int n, cyc;
    logic [TW-1:0] o0, o1;
    model(t, cull, clip, n, o0, o1);
    if (n >= 1) exp_q.push_back('{v: o0, last: (n == 1)});
    if (n == 2) exp_q.push_back('{v: o1, last: 1'b1});
    if (STATS && cull) exp_cull++;
    if (STATS && clip) exp_clip++;
    wait_ready("accept_wait");
    in_vtx_i = t;
    in_valid_i = 1'b1;
    tick();
    in_valid_i = 1'b0;
    in_vtx_i = {12{$urandom}};
    if (lat > 0) begin
      cyc = 1;
      while (!(cull ? in_ready_o : out_valid_o) && cyc < 100) begin
        tick();
        cyc++;
      end
      chk("latency", TW'(cyc), TW'(lat));
    end
  endtask

  task automatic finish_tri();
    wait_ready("done_wait");
    chk("queue_drained", TW'(exp_q.size()), '0);
    chk("cull_count", cull_count_o, TW'(exp_cull));
    chk("clip_count", clip_count_o, TW'(exp_clip));
  endtask

  function automatic logic [TW-1:0] gen_tri();
    logic [TW-1:0] t;
    int w, x, y, z;
    for (int k = 0; k < 3; k++) begin
      w = int'($urandom_range(32'h4000, 32'h30000));
      x = int'($urandom_range(0, 3 * w)) - (3 * w) / 2;
      y = int'($urandom_range(0, 3 * w)) - (3 * w) / 2;
      z = int'($urandom_range(0, 2 * w)) - (3 * w) / 4;
      t[k*XW +: XW] = mk(x, y, z, w);
      if ($urandom_range(0, 9) == 0) t[k*XW +: XW] = {$urandom, $urandom, $urandom, $urandom};
    end
    return t;
  endfunction

  // Output scoreboard: every valid cycle must present the head of the expected queue
  always @(negedge clk_i) begin
    if (rst_ni && out_valid_o) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_output: got %h expected no output", out_vtx_o);
      end else begin
        chk("out_vtx", out_vtx_o, exp_q[0].v);
        chk("out_last", out_last_o, exp_q[0].last);
        chk("in_ready_in_emit", in_ready_o, '0);
        chk("busy_in_emit", busy_o, 1);
        if (out_ready_i) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk_i);
      #1;
      out_ready_i = bp_hold ? 1'b0 : (rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached with %0d checks", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [XW-1:0] p0, p1, p2, c0, n0, n1, n2, m0, m1, m2, ia, ib;
    logic [TW-1:0] pt, ct, ot, tt, o0, o1;
    bit cull, clip;
    int n;

    p0 = mk(0, 0, 32'h8000, 32'h10000);
    p1 = mk(32'h8000, 0, 32'h8000, 32'h10000);
    p2 = mk(0, 32'h8000, 32'h8000, 32'h10000);
    pt = {p2, p1, p0};
    c0 = mk(32'h20000, 0, 32'h8000, 32'h10000);
    ct = {c0, c0, c0};
    n0 = mk(0, 0, 32'h8000, 32'h10000);
    n1 = mk(32'h10000, 0, -32'h8000, 32'h10000);
    n2 = mk(0, 32'h10000, -32'h8000, 32'h10000);
    ot = {n2, n1, n0};
    m0 = mk(0, 0, -32'h8000, 32'h10000);
    m1 = mk(32'h10000, 0, 32'h8000, 32'h10000);
    m2 = mk(0, 32'h10000, 32'h8000, 32'h10000);
    tt = {m2, m1, m0};
    ia = mk(32'h8000, 0, 0, 32'h10000);
    ib = mk(0, 32'h8000, 0, 32'h10000);

    // Hand-computed expectations pin the reference model
    model(pt, cull, clip, n, o0, o1);
    chk("pin_pass", o0, pt);
    model(ct, cull, clip, n, o0, o1);
    chk("pin_cull", TW'(cull), 1);
    model(ot, cull, clip, n, o0, o1);
    chk("pin_one_in", o0, {ib, ia, n0});
    model(tt, cull, clip, n, o0, o1);
    chk("pin_two_in_tri0", o0, {m2, m1, ia});
    chk("pin_two_in_tri1", o1, {ib, m2, ia});

    tick();
    tick();
    chk("rst_in_ready", in_ready_o, 0);
    chk("rst_out_valid", out_valid_o, 0);
    chk("rst_out_last", out_last_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_out_vtx", out_vtx_o, '0);
    chk("rst_counters", {cull_count_o, clip_count_o}, '0);
    rst_ni = 1'b1;
    chk("in_ready_at_release", in_ready_o, 0);
    tick();
    chk("in_ready_after_release", in_ready_o, 1);

    send(pt, 2);
    finish_tri();
    send(ct, 2);
    finish_tri();
    send(ot, 36);
    finish_tri();

    bp_hold = 1'b1;
    send(tt, 36);
    for (int i = 0; i < 10; i++) begin
      chk("bp_valid_held", out_valid_o, 1);
      chk("bp_in_ready_low", in_ready_o, 0);
      tick();
    end
    bp_hold = 1'b0;
    finish_tri();

    // Reset while dividing
    send(ot, 0);
    repeat (5) tick();
    #2 rst_ni = 1'b0;
    #1;
    chk("mid_div_rst_valid", out_valid_o, 0);
    chk("mid_div_rst_busy", busy_o, 0);
    chk("mid_div_rst_counters", {cull_count_o, clip_count_o}, '0);
    exp_q.delete();
    exp_cull = 0;
    exp_clip = 0;
    tick();
    tick();
    rst_ni = 1'b1;
    tick();
    send(pt, 2);
    finish_tri();

    // Reset while a stalled output is presented
    bp_hold = 1'b1;
    send(ot, 36);
    repeat (3) tick();
    #2 rst_ni = 1'b0;
    #1;
    chk("emit_rst_valid_async", out_valid_o, 0);
    exp_q.delete();
    exp_cull = 0;
    exp_clip = 0;
    bp_hold = 1'b0;
    tick();
    rst_ni = 1'b1;
    tick();
    send(tt, 36);
    finish_tri();

    rand_rdy = 1'b1;
    for (int i = 0; i < 60; i++) begin
      send(gen_tri(), 0);
      finish_tri();
      repeat ($urandom_range(0, 2)) tick();
    end
    rand_rdy = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tri_near_clipper.md
# tri_near_clipper

Streaming homogeneous-space triangle clipper sitting between the vertex shader output and the rasteriser setup stage. It consumes one triangle per transaction, trivially rejects triangles wholly outside any of the six clip-space planes, and passes fully-visible triangles through unchanged. It clips triangles crossing the near plane (z = 0) into one or two triangles, which leave serially on a valid/ready stream with winding preserved.

## Interface
- VERTEX_WIDTH, 32: signed fixed-point component width.
- FRAC_BITS, 16: fractional bits of the coordinate format and of the interpolation factor t. Must satisfy FRAC_BITS < VERTEX_WIDTH.
- clk_i  in  1  clock.
- rst_ni  in  1  reset. Asynchronous, active-low.
- in_valid_i  in  1  input triangle valid.
- in_ready_o  out  1  clipper idle and able to accept.
- in_vtx_i  in  12*VERTEX_WIDTH  {v2,v1,v0}, each vertex {w,z,y,x}, signed.
- out_valid_o  out  1  output triangle valid.
- out_ready_i  in  1  downstream accepts.
- out_vtx_o  out  12*VERTEX_WIDTH  same packing as in_vtx_i.
- out_last_o  out  1  final output triangle of the current input primitive.
- busy_o  out  1  a primitive is held (any state other than IDLE).
- cull_count_o  out  16  saturating count of culled triangles.
- clip_count_o  out  16  saturating count of near-clipped triangles.

## Operation
- FSM states: IDLE, CLASSIFY, DIV, LERP, EMIT.
  - IDLE → CLASSIFY on in_valid_i && in_ready_o; the triangle is latched.
  - CLASSIFY → IDLE on cull; → EMIT when all three vertices satisfy z ≥ 0; otherwise → DIV.
  - DIV → LERP → DIV (second intersection) → LERP → EMIT.
  - EMIT → IDLE when out_last_o is handshaken.
- in_ready_o is high only in IDLE. It is registered and rises one cycle after reset release.
- Outcode per vertex, using signed compares: {x<−w, x>w, y<−w, y>w, z<0, z>w}. Cull if the bitwise AND of the three outcodes ≠ 0.
- Near flag n_k = z_k < 0; z = 0 counts as inside.
- Rotation r picks the odd-one-out vertex, giving A = v[r], B = v[r+1 mod 3], C = v[r+2 mod 3]. Ties resolve to the lowest index.
- One inside (A inside):
  - emit (A, I_AB, I_AC).
- Two inside (A outside):
  - tri0 = (I_AB, B, C);
  - tri1 = (I_AB, C, I_AC).
- Intersection I between inside vertex p and outside vertex q:
  - t = z_p / (z_p − z_q), unsigned restoring division, FRAC_BITS quotient bits, 0 ≤ t < 1.
  - Computed at VERTEX_WIDTH+1 bits, so the subtraction cannot overflow.
  - I = p + ((t·(q−p)) >>> FRAC_BITS) per component: full-width product, arithmetic shift, truncate to VERTEX_WIDTH.
  - I.z is forced to exactly 0.
- EMIT: out_vtx_o and out_last_o stay stable while out_valid_o && !out_ready_i.
- Reset mid-operation:
  - the primitive is discarded and the FSM returns to IDLE;
  - out_valid_o drops immediately (asynchronously);
  - counters clear.

## Timing
- Reset values:
  - in_ready_o, out_valid_o, out_last_o, busy_o: 0;
  - out_vtx_o: 0;
  - counters: 0.
- Accept in cycle 0; CLASSIFY in cycle 1.
- Pass-through: out_valid_o is high at cycle 2.
- Cull: in_ready_o is high again at cycle 2.
- DIV takes FRAC_BITS cycles and LERP takes 1 cycle, per intersection.
- First clipped output is valid at cycle 2 + 2·(FRAC_BITS+1), which is 36 at default parameters.
- A second triangle presents the cycle after the first triangle's handshake.
- Next accept is possible in the cycle after the last output handshake.

## Configuration
- CLIP_STATS_EN defined:
  - cull_count_o increments on each cull; clip_count_o increments on each primitive entering DIV.
  - Both saturate at 0xFFFF.
- CLIP_STATS_EN undefined:
  - counter logic is omitted; both ports are tied to 0.

## Test plan
Coordinates are Q16.16; 1.0 = 0x10000.
- Pass-through: v0=(0,0,0.5,1), v1=(0.5,0,0.5,1), v2=(0,0.5,0.5,1) → one triangle identical to input, out_last_o=1, valid at cycle 2.
- Cull: all three vertices with x=2.0, w=1.0 → no output; cull_count_o=1; in_ready_o high at cycle 2.
- One inside: v0=(0,0,0.5,1), v1=(1,0,−0.5,1), v2=(0,1,−0.5,1) → single triangle (v0, (0.5,0,0,1), (0,0.5,0,1)) at cycle 36, out_last_o=1.
- Two inside: v0=(0,0,−0.5,1), v1=(1,0,0.5,1), v2=(0,1,0.5,1) → tri0 = ((0.5,0,0,1), v1, v2), then tri1 = ((0.5,0,0,1), v2, (0,0.5,0,1)) with out_last_o=1.
- Backpressure: hold out_ready_i=0 for 10 cycles during EMIT → outputs stable and in_ready_o=0 throughout; exactly one handshake per triangle.
- Reset: assert rst_ni=0 mid-DIV → out_valid_o=0 and counters 0; the next triangle after reset processes normally.
